// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into one-cycle click, double-click,
// long-press and auto-repeat events. All timing is counted in clk cycles.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 3,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic single_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    PRESS1,
    WAIT_GAP,
    LONG_HELD,
    PRESS2
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  // Zero-period repeat has no terminal count; the branch using it is gated off.
  localparam logic [CNT_W-1:0] REP_LAST  =
    (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      ARM: begin
        if (!clean) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (clean) begin
          state_d = PRESS1;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS1: begin
        if (!clean) begin
          state_d = WAIT_GAP;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_GAP: begin
        // A re-press wins over gap expiry on the same edge.
        if (clean) begin
          double_d = 1'b1;
          state_d  = PRESS2;
          cnt_d    = '0;
        end else if (cnt_q == GAP_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!clean) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REPEAT_CYCLES != 0) begin
          if (cnt_q == REP_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PRESS2: begin
        if (!clean) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARM;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  assign single_pulse = single_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign held = (state_q == PRESS1) || (state_q == LONG_HELD) || (state_q == PRESS2);

endmodule
